// File: rtl/vga_frame_blitter_if.sv
// Framebuffer-side bus of vga_frame_blitter: shared background/glyph ROM read port
// plus the pixel write port towards the VGA adapter.
interface vga_frame_blitter_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 3
);
    logic [ADDR_W-1:0]  oRomAddr;
    logic [3:0]         oGlyphSel;
    logic [COLOR_W-1:0] iBgColor;
    logic [COLOR_W-1:0] iGlyphColor;
    logic [X_W-1:0]     oX;
    logic [Y_W-1:0]     oY;
    logic [COLOR_W-1:0] oColor;
    logic               oWriteEn;

    modport master (
        output oRomAddr, oGlyphSel, oX, oY, oColor, oWriteEn,
        input  iBgColor, iGlyphColor
    );
    modport slave (
        input  oRomAddr, oGlyphSel, oX, oY, oColor, oWriteEn,
        output iBgColor, iGlyphColor
    );
endinterface

// File: rtl/vga_frame_blitter.sv
// Per-frame pixel writer: background, optional BCD glyph row and clipped cursor, one pixel per cycle.
// Optional build macro VGA_GLYPH_TRANSPARENCY_EN: glyph pixels equal to TRANSP_COLOR are not written.
module vga_frame_blitter #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int X_W          = 9,
    parameter int Y_W          = 8,
    parameter int ADDR_W       = 17,
    parameter int COLOR_W      = 3,
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_W      = 17,
    parameter int DIGIT_H      = 17,
    parameter int DIGIT_X0     = 120,
    parameter int DIGIT_Y0     = 155,
    parameter int SCORE_SCREEN = 3,
    parameter int CURSOR_SIZE  = 4,
    parameter int CURSOR_COLOR = 0,
    parameter int TRANSP_COLOR = 7
) (
    input  logic                  clk,
    input  logic                  iReset,
    input  logic                  iVSync,
    input  logic [1:0]            iScreenSel,
    input  logic [4*N_DIGITS-1:0] iDigits,
    input  logic [X_W-1:0]        iMouseX,
    input  logic [Y_W-1:0]        iMouseY,
    output logic                  oBusy,
    output logic                  oFrameDone,
    output logic                  oOverrun,
    vga_frame_blitter_if.master   bus
);
    localparam int DIG_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int HALF      = CURSOR_SIZE / 2;
`ifdef VGA_GLYPH_TRANSPARENCY_EN
    localparam logic TRANSP_EN = 1'b1;
`else
    localparam logic TRANSP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_BG, S_DIGITS, S_CURSOR, S_DONE} state_t;
    typedef enum logic [1:0] {L_BG, L_GLYPH, L_CURSOR} layer_t;

    function automatic logic [3:0] f_digit(input logic [4*N_DIGITS-1:0] digits,
                                           input logic [DIG_IDX_W-1:0]  idx);
        f_digit = digits[4*(N_DIGITS-1-int'(idx)) +: 4];
    endfunction

    state_t                r_state;
    logic                  r_vs_prev;
    logic                  r_busy, r_done, r_overrun;
    logic [1:0]            r_screen;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [X_W-1:0]        r_mx, r_cx;
    logic [Y_W-1:0]        r_my, r_cy;
    logic [DIG_IDX_W-1:0]  r_dig;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic [3:0]            r_glyph_sel;
    // Pixel stage: one cycle behind the address, aligned with ROM data.
    logic [X_W-1:0]        r_p_x, r_hold_x;
    logic [Y_W-1:0]        r_p_y, r_hold_y;
    layer_t                r_p_layer;
    logic                  r_p_we;
    logic [COLOR_W-1:0]    r_hold_c;

    logic                  w_fall, w_bg_last, w_glyph_end, w_dig_last, w_cur_last, w_cur_in;
    logic [X_W-1:0]        w_glyph_x;
    logic [Y_W-1:0]        w_glyph_y;
    logic signed [X_W:0]   w_cur_x;
    logic signed [Y_W:0]   w_cur_y;
    logic [COLOR_W-1:0]    w_col;
    logic                  w_is_key, w_we;

    assign w_fall      = r_vs_prev & ~iVSync;
    assign w_bg_last   = (r_cx == X_W'(H_RES-1)) && (r_cy == Y_W'(V_RES-1));
    assign w_glyph_end = (r_cx == X_W'(DIGIT_W-1)) && (r_cy == Y_W'(DIGIT_H-1));
    assign w_dig_last  = w_glyph_end && (r_dig == DIG_IDX_W'(N_DIGITS-1));
    assign w_cur_last  = (r_cx == X_W'(CURSOR_SIZE-1)) && (r_cy == Y_W'(CURSOR_SIZE-1));
    assign w_glyph_x   = X_W'(DIGIT_X0) + X_W'(r_dig) * X_W'(DIGIT_W) + r_cx;
    assign w_glyph_y   = Y_W'(DIGIT_Y0) + r_cy;
    // Cursor origin may fall left of / above the screen, hence one extra signed bit.
    assign w_cur_x     = $signed({1'b0, r_mx}) + $signed({1'b0, r_cx}) - $signed((X_W+1)'(HALF));
    assign w_cur_y     = $signed({1'b0, r_my}) + $signed({1'b0, r_cy}) - $signed((Y_W+1)'(HALF));
    assign w_cur_in    = !w_cur_x[X_W] && (w_cur_x < $signed((X_W+1)'(H_RES))) &&
                         !w_cur_y[Y_W] && (w_cur_y < $signed((Y_W+1)'(V_RES)));

    // Frame sequencer: issues one ROM address per cycle and stages the pixel it belongs to.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_state     <= S_IDLE;
            r_vs_prev   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_screen    <= 2'd0;
            r_digits    <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_dig       <= '0;
            r_rom_addr  <= '0;
            r_glyph_sel <= 4'd0;
            r_p_x       <= '0;
            r_p_y       <= '0;
            r_p_layer   <= L_BG;
            r_p_we      <= 1'b0;
        end else begin
            r_vs_prev <= iVSync;
            r_done    <= 1'b0;
            r_overrun <= w_fall & r_busy;
            r_p_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_screen   <= iScreenSel;
                        r_digits   <= iDigits;
                        r_mx       <= iMouseX;
                        r_my       <= iMouseY;
                        r_cx       <= '0;
                        r_cy       <= '0;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BG;
                    end
                end
                S_BG: begin
                    r_p_x     <= r_cx;
                    r_p_y     <= r_cy;
                    r_p_layer <= L_BG;
                    r_p_we    <= 1'b1;
                    if (w_bg_last) begin
                        r_cx <= '0;
                        r_cy <= '0;
                        if (r_screen == 2'(SCORE_SCREEN)) begin
                            r_dig       <= '0;
                            r_rom_addr  <= '0;
                            r_glyph_sel <= f_digit(r_digits, '0);
                            r_state     <= S_DIGITS;
                        end else begin
                            r_state <= S_CURSOR;
                        end
                    end else begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        if (r_cx == X_W'(H_RES-1)) begin
                            r_cx <= '0;
                            r_cy <= r_cy + Y_W'(1);
                        end else begin
                            r_cx <= r_cx + X_W'(1);
                        end
                    end
                end
                S_DIGITS: begin
                    r_p_x     <= w_glyph_x;
                    r_p_y     <= w_glyph_y;
                    r_p_layer <= L_GLYPH;
                    r_p_we    <= (r_glyph_sel <= 4'd9);
                    if (w_glyph_end) begin
                        r_cx       <= '0;
                        r_cy       <= '0;
                        r_rom_addr <= '0;
                        if (w_dig_last) begin
                            r_state <= S_CURSOR;
                        end else begin
                            r_dig       <= r_dig + DIG_IDX_W'(1);
                            r_glyph_sel <= f_digit(r_digits, r_dig + DIG_IDX_W'(1));
                        end
                    end else begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        if (r_cx == X_W'(DIGIT_W-1)) begin
                            r_cx <= '0;
                            r_cy <= r_cy + Y_W'(1);
                        end else begin
                            r_cx <= r_cx + X_W'(1);
                        end
                    end
                end
                S_CURSOR: begin
                    r_p_x     <= w_cur_x[X_W-1:0];
                    r_p_y     <= w_cur_y[Y_W-1:0];
                    r_p_layer <= L_CURSOR;
                    r_p_we    <= w_cur_in;
                    if (w_cur_last) begin
                        r_state <= S_DONE;
                    end else if (r_cx == X_W'(CURSOR_SIZE-1)) begin
                        r_cx <= '0;
                        r_cy <= r_cy + Y_W'(1);
                    end else begin
                        r_cx <= r_cx + X_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Colour source of the staged pixel; ROM data arrives this cycle.
    always_comb begin
        w_col = COLOR_W'(CURSOR_COLOR);
        case (r_p_layer)
            L_BG:    w_col = bus.iBgColor;
            L_GLYPH: w_col = bus.iGlyphColor;
            default: w_col = COLOR_W'(CURSOR_COLOR);
        endcase
    end

    assign w_is_key = (r_p_layer == L_GLYPH) && (bus.iGlyphColor == COLOR_W'(TRANSP_COLOR));
    assign w_we     = r_p_we && !(TRANSP_EN && w_is_key);

    // Last written pixel, presented while no pixel is valid.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_hold_x <= '0;
            r_hold_y <= '0;
            r_hold_c <= '0;
        end else if (w_we) begin
            r_hold_x <= r_p_x;
            r_hold_y <= r_p_y;
            r_hold_c <= w_col;
        end
    end

    assign bus.oRomAddr  = r_rom_addr;
    assign bus.oGlyphSel = r_glyph_sel;
    assign bus.oWriteEn  = w_we;
    assign bus.oX        = w_we ? r_p_x : r_hold_x;
    assign bus.oY        = w_we ? r_p_y : r_hold_y;
    assign bus.oColor    = w_we ? w_col : r_hold_c;
    assign oBusy         = r_busy;
    assign oFrameDone    = r_done;
    assign oOverrun      = r_overrun;
endmodule
